// File: rtl/iob_gpio_in_pkg.sv
// Shared constants for the GPIO input block: register word addresses,
// default debounce width and register reset values.
package iob_gpio_in_pkg;

  localparam int unsigned DEB_W_DEF = 16;

  localparam logic [31:0] ADDR_RAW     = 32'd0;
  localparam logic [31:0] ADDR_DEB     = 32'd1;
  localparam logic [31:0] ADDR_RISE_EN = 32'd2;
  localparam logic [31:0] ADDR_FALL_EN = 32'd3;
  localparam logic [31:0] ADDR_PENDING = 32'd4;
  localparam logic [31:0] ADDR_DEB_TH  = 32'd5;

  localparam logic [31:0] EN_RST      = 32'h0000_0000;
  localparam logic [31:0] PENDING_RST = 32'h0000_0000;
  localparam logic [31:0] DEB_TH_RST  = 32'h0000_0000;

endpackage

// File: rtl/iob_gpio_in_if.sv
// CPU native bus between a master (CPU) and the GPIO input slave.
interface iob_gpio_in_if #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 3
);
  logic                valid;
  logic [ADDR_W-1:0]   address;
  logic [DATA_W-1:0]   wdata;
  logic [DATA_W/8-1:0] wstrb;
  logic [DATA_W-1:0]   rdata;
  logic                ready;

  modport master (output valid, address, wdata, wstrb, input rdata, ready);
  modport slave  (input valid, address, wdata, wstrb, output rdata, ready);
endinterface

// File: rtl/iob_gpio_in_deb.sv
// One input pin: two-flop synchronizer, mismatch-count debouncer, and
// edge outputs that are valid on the cycle the debounced value updates.
module iob_gpio_in_deb #(
  parameter int DEB_W = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             pin,
  input  logic [DEB_W-1:0] th,
  output logic             raw,
  output logic             deb,
  output logic             rise,
  output logic             fall
);

  logic             sync1_q, sync2_q;
  logic             deb_q, deb_d;
  logic [DEB_W-1:0] cnt_q, cnt_d;

  always_comb begin
    deb_d = deb_q;
    cnt_d = cnt_q;
    if (sync2_q == deb_q) begin
      cnt_d = '0;
    end else if (cnt_q >= th) begin
      deb_d = sync2_q;
      cnt_d = '0;
    end else if (cnt_q != '1) begin
      cnt_d = cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync1_q <= 1'b0;
      sync2_q <= 1'b0;
      deb_q   <= 1'b0;
      cnt_q   <= '0;
    end else begin
      sync1_q <= pin;
      sync2_q <= sync1_q;
      deb_q   <= deb_d;
      cnt_q   <= cnt_d;
    end
  end

  // Edges come from the next-state so pending can latch on the same edge as deb.
  assign rise = deb_d & ~deb_q;
  assign fall = ~deb_d & deb_q;
  assign raw  = sync2_q;
  assign deb  = deb_q;

endmodule

// File: rtl/iob_gpio_in.sv
// GPIO input peripheral: per-pin debounce instances plus the bus register
// file, edge enables, write-1-to-clear pending latch and level interrupt.
module iob_gpio_in
  import iob_gpio_in_pkg::*;
#(
  parameter int GPIO_W = 32,
  parameter int DATA_W = 32,
  parameter int ADDR_W = 3,
  parameter int DEB_W  = DEB_W_DEF
) (
  input  logic              clk,
  input  logic              rst,
  iob_gpio_in_if.slave      bus,
  input  logic [GPIO_W-1:0] gpio_input,
  output logic              gpio_irq
);

  logic [GPIO_W-1:0] raw, deb, rise, fall;
  logic [DATA_W-1:0] wmask;

  logic              ready_q, ready_d;
  logic [DATA_W-1:0] rdata_q, rdata_d;
  logic [GPIO_W-1:0] rise_en_q, rise_en_d;
  logic [GPIO_W-1:0] fall_en_q, fall_en_d;
  logic [GPIO_W-1:0] pending_q, pending_d;
  logic [DEB_W-1:0]  deb_th_q, deb_th_d;
  logic              irq_q, irq_d;

  logic              req, wr, rd;
  logic [31:0]       addr_w;
  logic [DATA_W-1:0] rise_merge, fall_merge, th_merge, w1c_bits;
  logic              unused_bits;

  genvar gi;
  generate
    for (gi = 0; gi < GPIO_W; gi++) begin : g_pin
      iob_gpio_in_deb #(.DEB_W(DEB_W)) u_deb (
        .clk  (clk),
        .rst  (rst),
        .pin  (gpio_input[gi]),
        .th   (deb_th_q),
        .raw  (raw[gi]),
        .deb  (deb[gi]),
        .rise (rise[gi]),
        .fall (fall[gi])
      );
    end
    for (gi = 0; gi < DATA_W/8; gi++) begin : g_lane
      assign wmask[8*gi +: 8] = {8{bus.wstrb[gi]}};
    end
  endgenerate

  // A request is accepted only when no ack is outstanding, so a held valid
  // becomes a new request every second cycle.
  always_comb begin
    req    = bus.valid & ~ready_q;
    wr     = req & (|bus.wstrb);
    rd     = req & ~(|bus.wstrb);
    addr_w = 32'(bus.address);

    rise_merge = (DATA_W'(rise_en_q) & ~wmask) | (bus.wdata & wmask);
    fall_merge = (DATA_W'(fall_en_q) & ~wmask) | (bus.wdata & wmask);
    th_merge   = (DATA_W'(deb_th_q)  & ~wmask) | (bus.wdata & wmask);
    w1c_bits   = bus.wdata & wmask;

    rise_en_d = rise_en_q;
    fall_en_d = fall_en_q;
    deb_th_d  = deb_th_q;
    pending_d = pending_q;

    if (wr) begin
      case (addr_w)
        ADDR_RISE_EN: rise_en_d = GPIO_W'(rise_merge);
        ADDR_FALL_EN: fall_en_d = GPIO_W'(fall_merge);
        ADDR_DEB_TH:  deb_th_d  = DEB_W'(th_merge);
        ADDR_PENDING: pending_d = pending_q & ~GPIO_W'(w1c_bits);
        default: ;
      endcase
    end
    // New events are OR-ed after the clear so a same-cycle event survives W1C.
    pending_d = pending_d | (rise & rise_en_q) | (fall & fall_en_q);
    irq_d     = |pending_d;

    ready_d = req;
    rdata_d = '0;
    if (rd) begin
      case (addr_w)
        ADDR_RAW:     rdata_d = DATA_W'(raw);
        ADDR_DEB:     rdata_d = DATA_W'(deb);
        ADDR_RISE_EN: rdata_d = DATA_W'(rise_en_q);
        ADDR_FALL_EN: rdata_d = DATA_W'(fall_en_q);
        ADDR_PENDING: rdata_d = DATA_W'(pending_q);
        ADDR_DEB_TH:  rdata_d = DATA_W'(deb_th_q);
        default:      rdata_d = '0;
      endcase
    end
  end

  assign unused_bits = ^{rise_merge, fall_merge, th_merge, w1c_bits};

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ready_q   <= 1'b0;
      rdata_q   <= '0;
      rise_en_q <= GPIO_W'(EN_RST);
      fall_en_q <= GPIO_W'(EN_RST);
      pending_q <= GPIO_W'(PENDING_RST);
      deb_th_q  <= DEB_W'(DEB_TH_RST);
      irq_q     <= 1'b0;
    end else begin
      ready_q   <= ready_d;
      rdata_q   <= rdata_d;
      rise_en_q <= rise_en_d;
      fall_en_q <= fall_en_d;
      pending_q <= pending_d;
      deb_th_q  <= deb_th_d;
      irq_q     <= irq_d;
    end
  end

  assign bus.ready = ready_q;
  assign bus.rdata = rdata_q;
  assign gpio_irq  = irq_q;

endmodule

// File: tb/tb_iob_gpio_in.sv
// Directed bench for iob_gpio_in: bus access, debounce timing, edge events,
// W1C race and asynchronous reset.
module tb_iob_gpio_in;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [31:0] gpio_input = 32'h0;
  logic        gpio_irq;
  int          tests_run = 0;
  int          tests_failed = 0;

  iob_gpio_in_if #(.DATA_W(32), .ADDR_W(3)) bus ();

  iob_gpio_in #(.GPIO_W(32), .DATA_W(32), .ADDR_W(3), .DEB_W(16)) dut (
    .clk        (clk),
    .rst        (rst),
    .bus        (bus),
    .gpio_input (gpio_input),
    .gpio_irq   (gpio_irq)
  );

  always #5 clk = ~clk;

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  // One bus transaction; starts and ends 1 time unit after a rising edge.
  task automatic xfer(input logic [2:0] a, input logic [31:0] d, input logic [3:0] s,
                      output logic [31:0] r);
    bus.address = a;
    bus.wdata   = d;
    bus.wstrb   = s;
    bus.valid   = 1'b1;
    @(posedge clk);
    #1;
    tests_run++;
    if (bus.ready !== 1'b1) begin
      tests_failed++;
      $display("FAIL bus_ready addr=%0d got=%b want=1", a, bus.ready);
    end
    r = bus.rdata;
    $display("[TB] xfer addr=%0d wdata=%h wstrb=%b rdata=%h", a, d, s, r);
    bus.valid = 1'b0;
    bus.wstrb = 4'h0;
    @(posedge clk);
    #1;
  endtask

  task automatic wr(input logic [2:0] a, input logic [31:0] d);
    logic [31:0] r;
    xfer(a, d, 4'hF, r);
  endtask

  task automatic rd(input logic [2:0] a, output logic [31:0] r);
    xfer(a, 32'h0, 4'h0, r);
  endtask

  task automatic test_reset();
    logic [31:0] r;
    rst = 1'b1;
    tick(3);
    tests_run++;
    if (bus.ready !== 1'b0 || bus.rdata !== 32'h0 || gpio_irq !== 1'b0) begin
      tests_failed++;
      $display("FAIL reset_outputs got ready=%b rdata=%h irq=%b want 0/0/0",
               bus.ready, bus.rdata, gpio_irq);
    end
    rst = 1'b0;
    tick(1);
    for (int a = 0; a < 8; a++) begin
      rd(3'(a), r);
      tests_run++;
      if (r !== 32'h0) begin
        tests_failed++;
        $display("FAIL reset_read addr=%0d got=%h want=0", a, r);
      end
    end
    tests_run++;
    if (gpio_irq !== 1'b0) begin
      tests_failed++;
      $display("FAIL reset_irq got=%b want=0", gpio_irq);
    end
  endtask

  task automatic test_bypass();
    logic [31:0] r;
    wr(3'd5, 32'd0);
    wr(3'd2, 32'h1);
    gpio_input[0] = 1'b1;
    tick(2);
    tests_run++;
    if (gpio_irq !== 1'b0) begin
      tests_failed++;
      $display("FAIL bypass_irq_early got=%b want=0", gpio_irq);
    end
    tick(1);
    tests_run++;
    if (gpio_irq !== 1'b1) begin
      tests_failed++;
      $display("FAIL bypass_irq_edge3 got=%b want=1", gpio_irq);
    end
    rd(3'd1, r);
    tests_run++;
    if (r !== 32'h1) begin
      tests_failed++;
      $display("FAIL bypass_deb got=%h want=00000001", r);
    end
    rd(3'd4, r);
    tests_run++;
    if (r !== 32'h1) begin
      tests_failed++;
      $display("FAIL bypass_pending got=%h want=00000001", r);
    end
    wr(3'd4, 32'h1);
    tests_run++;
    if (gpio_irq !== 1'b0) begin
      tests_failed++;
      $display("FAIL bypass_w1c_irq got=%b want=0", gpio_irq);
    end
    rd(3'd4, r);
    tests_run++;
    if (r !== 32'h0) begin
      tests_failed++;
      $display("FAIL bypass_w1c_pending got=%h want=0", r);
    end
  endtask

  task automatic test_debounce();
    logic [31:0] r;
    wr(3'd5, 32'd4);
    wr(3'd2, 32'h8);
    gpio_input[3] = 1'b1;
    tick(4);
    gpio_input[3] = 1'b0;
    tick(10);
    tests_run++;
    if (gpio_irq !== 1'b0) begin
      tests_failed++;
      $display("FAIL glitch_irq got=%b want=0", gpio_irq);
    end
    rd(3'd1, r);
    tests_run++;
    if (r !== 32'h1) begin
      tests_failed++;
      $display("FAIL glitch_deb got=%h want=00000001", r);
    end
    gpio_input[3] = 1'b1;
    for (int i = 1; i <= 7; i++) begin
      tick(1);
      if (i == 6) gpio_input[3] = 1'b0;
      tests_run++;
      if (gpio_irq !== (i == 7)) begin
        tests_failed++;
        $display("FAIL pulse_irq edge=%0d got=%b want=%b", i, gpio_irq, (i == 7));
      end
    end
    rd(3'd1, r);
    tests_run++;
    if (r !== 32'h9) begin
      tests_failed++;
      $display("FAIL pulse_deb got=%h want=00000009", r);
    end
    rd(3'd4, r);
    tests_run++;
    if (r !== 32'h8) begin
      tests_failed++;
      $display("FAIL pulse_pending got=%h want=00000008", r);
    end
    tick(8);
    wr(3'd4, 32'h8);
    rd(3'd4, r);
    tests_run++;
    if (r !== 32'h0 || gpio_irq !== 1'b0) begin
      tests_failed++;
      $display("FAIL pulse_clear got pending=%h irq=%b want 0/0", r, gpio_irq);
    end
  endtask

  task automatic test_w1c_race();
    logic [31:0] r;
    wr(3'd5, 32'd0);
    gpio_input[7] = 1'b1;
    tick(5);
    wr(3'd3, 32'h80);
    gpio_input[7] = 1'b0;
    tick(2);
    wr(3'd4, 32'h80);
    tests_run++;
    if (gpio_irq !== 1'b1) begin
      tests_failed++;
      $display("FAIL race_irq got=%b want=1", gpio_irq);
    end
    rd(3'd4, r);
    tests_run++;
    if (r !== 32'h80) begin
      tests_failed++;
      $display("FAIL race_pending got=%h want=00000080", r);
    end
    wr(3'd4, 32'h80);
    rd(3'd4, r);
    tests_run++;
    if (r !== 32'h0 || gpio_irq !== 1'b0) begin
      tests_failed++;
      $display("FAIL race_clear got pending=%h irq=%b want 0/0", r, gpio_irq);
    end
  endtask

  task automatic test_wstrb();
    logic [31:0] r;
    wr(3'd2, 32'h0);
    xfer(3'd2, 32'h1234_FF56, 4'b0010, r);
    rd(3'd2, r);
    tests_run++;
    if (r !== 32'h0000_FF00) begin
      tests_failed++;
      $display("FAIL wstrb_lane got=%h want=0000ff00", r);
    end
    xfer(3'd2, 32'hFFFF_FFFF, 4'b0000, r);
    rd(3'd2, r);
    tests_run++;
    if (r !== 32'h0000_FF00) begin
      tests_failed++;
      $display("FAIL wstrb_zero got=%h want=0000ff00", r);
    end
    wr(3'd6, 32'hFFFF_FFFF);
    rd(3'd6, r);
    tests_run++;
    if (r !== 32'h0) begin
      tests_failed++;
      $display("FAIL addr6 got=%h want=0", r);
    end
    rd(3'd3, r);
    tests_run++;
    if (r !== 32'h80) begin
      tests_failed++;
      $display("FAIL fall_en_readback got=%h want=00000080", r);
    end
    wr(3'd5, 32'hFFFF_FFFF);
    rd(3'd5, r);
    tests_run++;
    if (r !== 32'h0000_FFFF) begin
      tests_failed++;
      $display("FAIL deb_th_width got=%h want=0000ffff", r);
    end
    wr(3'd5, 32'h0);
  endtask

  task automatic test_reset_mid();
    logic [31:0] r;
    wr(3'd2, 32'hFFFF_FFFF);
    wr(3'd3, 32'hFFFF_FFFF);
    gpio_input = 32'hA5;
    tick(5);
    rd(3'd4, r);
    tests_run++;
    if (r !== 32'hA4 || gpio_irq !== 1'b1) begin
      tests_failed++;
      $display("FAIL pre_reset got pending=%h irq=%b want a4/1", r, gpio_irq);
    end
    wr(3'd5, 32'd4);
    gpio_input = 32'h5A;
    tick(3);
    rst = 1'b1;
    #1;
    tests_run++;
    if (gpio_irq !== 1'b0 || bus.ready !== 1'b0 || bus.rdata !== 32'h0) begin
      tests_failed++;
      $display("FAIL async_reset got irq=%b ready=%b rdata=%h want 0/0/0",
               gpio_irq, bus.ready, bus.rdata);
    end
    gpio_input = 32'hA5;
    @(posedge clk);
    @(posedge clk);
    #1;
    rst = 1'b0;
    tick(2);
    rd(3'd1, r);
    tests_run++;
    if (r !== 32'h0) begin
      tests_failed++;
      $display("FAIL post_reset_deb_early got=%h want=0", r);
    end
    rd(3'd1, r);
    tests_run++;
    if (r !== 32'hA5) begin
      tests_failed++;
      $display("FAIL post_reset_deb got=%h want=000000a5", r);
    end
    rd(3'd4, r);
    tests_run++;
    if (r !== 32'h0 || gpio_irq !== 1'b0) begin
      tests_failed++;
      $display("FAIL post_reset_pending got pending=%h irq=%b want 0/0", r, gpio_irq);
    end
  endtask

  initial begin
    bus.valid   = 1'b0;
    bus.address = 3'd0;
    bus.wdata   = 32'h0;
    bus.wstrb   = 4'h0;
    test_reset();
    test_bypass();
    test_debounce();
    test_w1c_race();
    test_wstrb();
    test_reset_mid();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule

// File: doc/iob_gpio_in.md
# iob_gpio_in

Input-side companion to the GPIO output peripheral: samples the external `gpio_input` pins, synchronizes and debounces each bit, detects rising/falling edges and latches enabled edge events into a write-1-to-clear pending register that drives a level interrupt. It sits on the CPU native slave bus beside the output block and owns everything pin-to-CPU.

## Interface
- `GPIO_W`, default 32: number of input pins (≤ `DATA_W`).
- `DATA_W`, default 32: CPU data width.
- `ADDR_W`, default 3: CPU word-address width.
- `DEB_W`, default 16: debounce threshold and counter width.

Ports:
- `clk`  in  1  system clock; single clock domain.
- `rst`  in  1  asynchronous, active-high reset.
- `valid`  in  1  CPU request strobe.
- `address`  in  `ADDR_W`  word address.
- `wdata`  in  `DATA_W`  write data.
- `wstrb`  in  `DATA_W/8`  byte write strobes; all-zero means read.
- `rdata`  out  `DATA_W`  read data, valid with `ready`.
- `ready`  out  1  request acknowledge.
- `gpio_input`  in  `GPIO_W`  asynchronous external pins.
- `gpio_irq`  out  1  interrupt, high while any pending bit set.

## Operation
- Register map (word address):
  - 0 `RAW` RO: synchronized pin value.
  - 1 `DEB` RO: debounced value.
  - 2 `RISE_EN` RW: per-bit rising-edge event enable.
  - 3 `FALL_EN` RW: per-bit falling-edge event enable.
  - 4 `PENDING` RO / W1C: latched events.
  - 5 `DEB_TH` RW, low `DEB_W` bits: debounce threshold.
  - 6–7: read 0, writes ignored.
- Writes honour `wstrb` per byte lane; bits above `GPIO_W` (or `DEB_W`) read 0.
- Synchronizer: two flops per bit, no reset dependency on pin level.
- Debounce, per bit, mismatch counter `cnt`:
  - `sync == deb`: `cnt <= 0`.
  - `sync != deb` and `cnt >= DEB_TH`: `deb <= sync`, `cnt <= 0`.
  - otherwise: `cnt <= cnt + 1`; saturates at all-ones.
  - `DEB_TH` = 0 means bypass: deb follows sync one cycle later.
  - `DEB_TH` change mid-count: takes effect immediately on the next compare; `cnt` is not cleared.
- Edge events: rise = deb 0→1, fall = deb 1→0, on the edge `deb` updates.
- Pending bit i sets when (rise & `RISE_EN`[i]) | (fall & `FALL_EN`[i]).
- W1C: writing 1 clears the bit. An event on the same cycle as its W1C wins (bit stays set).
- Disabling an enable does not clear existing pending bits.
- `gpio_irq` = OR of `PENDING`, driven from flops and glitch-free.

## Timing
- Reset values: `rdata` 0, `ready` 0, `gpio_irq` 0. `RISE_EN`, `FALL_EN`, `PENDING` and `DEB_TH` reset to 0, as do the sync flops, `deb` and every `cnt`.
- Bus: `ready` pulses high for one cycle, one cycle after `valid`. A write takes effect on that same edge. `rdata` is registered and held only while `ready` is high, 0 otherwise. Back-to-back requests are allowed every other cycle; `valid` held high is treated as a new request every second cycle.
- A read of `PENDING` and a W1C in separate transactions are independent. Events arriving between them are preserved.
- Latency from a stable pin change to the `deb` update: 3 + `DEB_TH` clock edges (2 sync + `DEB_TH`+1 debounce). `PENDING` and `gpio_irq` update on the same edge as `deb`.
- A pulse that disagrees with `deb` for fewer than `DEB_TH`+1 consecutive sync cycles is rejected and `cnt` restarts.
- Reset mid-operation clears all state asynchronously. After reset with a pin held high, `deb` rises after 3 cycles but no event is latched, because the enables are 0.

## Structure
- Shared package/header: register address constants, `DEB_W` default, register reset values.
- One sub-module `iob_gpio_in_deb`: a single-bit synchronizer plus debounce counter plus edge outputs, generated `GPIO_W` times. The top level holds the bus decode, enables, pending and irq.

## Test plan
- Reset, then read all 8 addresses: all 0; `gpio_irq`=0.
- `DEB_TH`=0, `RISE_EN`=1. Pin0 goes 0→1: `DEB`[0]=1 and `PENDING`=0x1 exactly 3 edges later, and `gpio_irq`=1. W1C with 0x1 → `PENDING`=0, irq=0.
- `DEB_TH`=4. A 4-cycle high glitch on pin3 → no `DEB` change, no event. A 6-cycle high pulse → `DEB`[3] rises 7 edges after the pin edge.
- `FALL_EN`=0x80. Pin7 falls while a W1C of 0x80 lands on the same edge as the event → `PENDING`[7] remains 1.
- Write 0x0000FF00 with `wstrb`=0b0010 to `RISE_EN` → reads back 0x0000FF00. Then a write with `wstrb`=0 → unchanged. Address 6 reads 0.
- Pin pattern 0xA5 with all enables set, then assert `rst` mid-count → all outputs 0 immediately. After release with `DEB_TH`=0, `DEB`=0xA5 at cycle 3 and `PENDING`=0.
